csidh_limb_carry_norm: RTL and testbench
========================================

# csidh_limb_carry_norm

Streaming carry-normalisation stage for reduced-radix CSIDH-512 operands on the RV64 datapath. It sits directly downstream of the shift-right-and-add datapath and consumes the unnormalised limbs that datapath produces, one 64-bit limb per transfer, least significant limb first. Every limb except the top one is reduced to RADIX bits, and each carry (limb sum >> RADIX) is folded into the next limb. Output limbs are emitted in order, so a full multi-precision result is normalised in a single pass without software carry chains.

## Interface
- `LIMBS`, 9: limbs per operand; must be ≥ 2.
- `RADIX`, 57: bits kept per normalised limb; must be in 1..63.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_limb` and `in_signed` are valid.
- `in_ready`  out  1  stage can accept a limb this cycle.
- `in_limb`  in  64  unnormalised limb, LSB-first order.
- `in_signed`  in  1  mode select; sampled only on limb 0. 1 = two's-complement limbs, 0 = unsigned.
- `out_valid`  out  1  `out_limb`, `out_last` and `out_ovf` are valid.
- `out_ready`  in  1  downstream accepts the output this cycle.
- `out_limb`  out  64  normalised limb.
- `out_last`  out  1  current output is the top limb (index LIMBS-1).
- `out_ovf`  out  1  top-limb overflow flag; meaningful only when `out_last`=1, otherwise 0.

## Operation
- Handshakes:
  - Input transfer occurs when `in_valid` && `in_ready`.
  - Output transfer occurs when `out_valid` && `out_ready`.
  - `in_ready` = !`out_valid` || `out_ready` (combinational), so full throughput is one limb per cycle.
- Internal state:
  - limb index `idx` (0..LIMBS-1).
  - carry register `c` (64 bits).
  - mode register `sgn`.
  - FSM with two states, IDLE and RUN.
- IDLE (`idx`=0):
  - On transfer: `sgn` ← `in_signed`; the carry used this cycle is forced to 0.
  - Go to RUN, `idx` ← 1.
- RUN:
  - Each transfer increments `idx`.
  - The transfer with `idx`=LIMBS-1 returns the FSM to IDLE with `idx` ← 0 and `c` ← 0.
- Per-limb arithmetic, with eff_c = 0 on limb 0 and `c` otherwise:
  - Unsigned: s = {1'b0,`in_limb`} + {1'b0,eff_c} (65 bits); c ← s[64:RADIX], zero-extended.
  - Signed: s = `in_limb` + eff_c (mod 2^64); c ← s >>> RADIX (arithmetic shift).
  - Limb index < LIMBS-1: `out_limb` ← s[RADIX-1:0], zero-extended to 64 bits; `out_last` ← 0; `out_ovf` ← 0.
  - Top limb: `out_limb` ← s[63:0] with no masking; `out_last` ← 1.
  - Top-limb `out_ovf`, unsigned mode: s[64].
  - Top-limb `out_ovf`, signed mode: (`in_limb`[63] == eff_c[63]) && (s[63] != `in_limb`[63]).
- `in_signed` is ignored on limbs 1..LIMBS-1.

## Timing
- Reset: `out_valid`=0, `out_limb`=0, `out_last`=0, `out_ovf`=0, `idx`=0, `c`=0, `sgn`=0, FSM=IDLE. `in_ready`=1 while in reset and afterwards until the first output is held.
- Latency: an output becomes valid the cycle after its input transfer (one registered stage).
- When an input transfer occurs, output registers load on that edge and `out_valid` ← 1.
- When an output transfer occurs with no input transfer, `out_valid` ← 0.
- When both transfers occur in the same cycle, the new output replaces the old one and `out_valid` stays 1.
- Output stability: `out_limb`, `out_last` and `out_ovf` are held stable while `out_valid` && !`out_ready`.
- Boundary: the top limb of one operand and limb 0 of the next operand may transfer on consecutive cycles with no bubble. Limb 0 always starts with zero carry.
- Reset mid-operand: all state is cleared asynchronously and any partial operand is discarded. The next transfer after reset is treated as limb 0.
- `in_valid` may drop between limbs of an operand; `idx` and `c` hold their values.

## Test plan
1. Unsigned carry chain (RADIX=57, LIMBS=9):
   - Stimulus: limb0=0x0200_0000_0000_0005, limb1=0x01FF_FFFF_FFFF_FFFF, limbs 2..8 = 0, `out_ready`=1.
   - Required: outputs 0x5, 0x0, 0x1, then 0×6; `out_last` only on the 9th output; `out_ovf`=0; one output per cycle, first output 1 cycle after the first transfer.
2. Signed borrow propagation:
   - Stimulus: `in_signed`=1, limb0=0xFFFF_FFFF_FFFF_FFFF, limbs 1..8 = 0.
   - Required: outputs 0..7 each 0x01FF_FFFF_FFFF_FFFF; output 8 = 0xFFFF_FFFF_FFFF_FFFF; `out_ovf`=0.
3. Unsigned top overflow:
   - Stimulus: limbs 0..6 = 0, limb7=0x0200_0000_0000_0000, limb8=0xFFFF_FFFF_FFFF_FFFF.
   - Required: output 7 = 0; output 8 = 0x0, with `out_last`=1 and `out_ovf`=1.
4. Backpressure:
   - Stimulus: hold `out_ready`=0 for 3 cycles while the first output is valid.
   - Required: `in_ready`=0 throughout; `out_limb` stable; no input consumed.
   - Then release `out_ready` with `in_valid` still high. Required: input and output transfers occur in the same cycle and the stream resumes with no lost or duplicated limb.
5. Back-to-back operands:
   - Stimulus: operand from scenario 1, then immediately an operand with limb0=0x7 and all other limbs 0.
   - Required: the second operand's output 0 = 0x7 (stale carry not applied); no idle cycle between the operands.
6. Reset mid-operand:
   - Stimulus: assert `rst` after 4 limbs, then send a fresh 9-limb operand.
   - Required: `out_valid` drops immediately on reset; the new operand is normalised exactly as in scenario 1 and `out_last` is asserted on its 9th output.

Source files
------------

// File: rtl/csidh_limb_carry_norm_if.sv
// Limb stream bundle for the CSIDH carry-normalisation stage: one limb in, one limb out.
interface csidh_limb_carry_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_limb;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_limb;
    logic        out_last;
    logic        out_ovf;

    // Stage side: consumes unnormalised limbs, produces normalised limbs
    modport slave (
        input  in_valid, in_limb, in_signed, out_ready,
        output in_ready, out_valid, out_limb, out_last, out_ovf
    );

    // Producer/consumer side wrapped around the stage
    modport master (
        output in_valid, in_limb, in_signed, out_ready,
        input  in_ready, out_valid, out_limb, out_last, out_ovf
    );
endinterface

// File: rtl/csidh_limb_carry_norm.sv
// Streaming carry normaliser: reduces each non-top limb to RADIX bits and folds the
// carry into the next limb, LSB limb first, one limb per cycle with one register stage.
module csidh_limb_carry_norm #(
    parameter int unsigned LIMBS = 9,
    parameter int unsigned RADIX = 57
) (
    input  logic                  clk,
    input  logic                  rst,
    csidh_limb_carry_norm_if.slave bus
);
    localparam int unsigned      IDX_W    = (LIMBS > 2) ? $clog2(LIMBS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(LIMBS - 1);
    localparam logic [63:0]      LOW_MASK = (64'd1 << RADIX) - 64'd1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [63:0]      r_c, w_c_nxt;
    logic             r_sgn, w_sgn_nxt;

    logic             r_out_valid;
    logic [63:0]      r_out_limb;
    logic             r_out_last;
    logic             r_out_ovf;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_first;
    logic             w_top;
    logic             w_sgn;
    logic [63:0]      w_eff_c;
    logic [64:0]      w_sum;
    logic [63:0]      w_s;
    logic [63:0]      w_carry;
    logic [63:0]      w_limb;
    logic             w_ovf;

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_limb  = r_out_limb;
    assign bus.out_last  = r_out_last;
    assign bus.out_ovf   = r_out_ovf;

    assign w_in_xfer  = bus.in_valid && bus.in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    // Per-limb add, carry extraction and top-limb overflow; limb 0 starts with zero carry
    always_comb begin
        w_first = (r_state == S_IDLE);
        w_top   = (r_state == S_RUN) && (r_idx == IDX_TOP);
        w_sgn   = w_first ? bus.in_signed : r_sgn;
        w_eff_c = w_first ? 64'd0 : r_c;
        w_sum   = {1'b0, bus.in_limb} + {1'b0, w_eff_c};
        w_s     = w_sum[63:0];
        w_carry = '0;
        w_limb  = '0;
        w_ovf   = 1'b0;
        if (w_sgn) begin
            w_carry = 64'($signed(w_s) >>> RADIX);
        end else begin
            w_carry = 64'(w_sum >> RADIX);
        end
        if (w_top) begin
            w_limb = w_s;
            w_ovf  = w_sgn ? ((bus.in_limb[63] == w_eff_c[63]) && (w_s[63] != bus.in_limb[63]))
                           : w_sum[64];
        end else begin
            w_limb = w_s & LOW_MASK;
        end
    end

    // Next-state logic: IDLE takes limb 0 and latches mode, RUN walks to the top limb
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_c_nxt     = r_c;
        w_sgn_nxt   = r_sgn;
        case (r_state)
            S_IDLE: begin
                if (w_in_xfer) begin
                    w_sgn_nxt   = bus.in_signed;
                    w_c_nxt     = w_carry;
                    w_idx_nxt   = IDX_W'(1);
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_in_xfer) begin
                    if (r_idx == IDX_TOP) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_c_nxt     = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                        w_c_nxt   = w_carry;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM and operand-context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_c     <= '0;
            r_sgn   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_c     <= w_c_nxt;
            r_sgn   <= w_sgn_nxt;
        end
    end

    // Output stage: load on input transfer, drain on output-only transfer, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_limb  <= '0;
            r_out_last  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_limb  <= w_limb;
            r_out_last  <= w_top;
            r_out_ovf   <= w_ovf;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_csidh_limb_carry_norm.sv
// Self-checking bench for csidh_limb_carry_norm: directed scenarios plus randomized
// operands and handshakes scored against an arithmetic reference model.
module tb_csidh_limb_carry_norm;
    localparam int unsigned LIMBS = 9;
    localparam int unsigned RADIX = 57;
    localparam logic [63:0] MASK  = 64'h01FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef logic [63:0] op_t [LIMBS];
    typedef struct {
        logic [63:0] limb;
        logic        sgn;
        logic [63:0] e_limb;
        logic        e_last;
        logic        e_ovf;
    } tx_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    tx_t  tx_q[$];
    tx_t  sb[$];

    csidh_limb_carry_norm_if bus ();

    csidh_limb_carry_norm #(.LIMBS(LIMBS), .RADIX(RADIX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Reference: exact multi-precision arithmetic, limb by limb
    function automatic void model(input op_t l, input bit sg, output op_t o, output bit ovf);
        logic [64:0] uacc;
        logic [64:0] ucar;
        logic [65:0] wide;
        longint      s;
        longint      c;
        ucar = '0;
        c    = 0;
        ovf  = 1'b0;
        for (int k = 0; k < LIMBS; k++) begin
            if (!sg) begin
                uacc = {1'b0, l[k]} + ucar;
                if (k < LIMBS - 1) begin
                    o[k] = uacc[63:0] & MASK;
                    ucar = uacc >> RADIX;
                end else begin
                    o[k] = uacc[63:0];
                    ovf  = uacc[64];
                end
            end else begin
                wide = {{2{l[k][63]}}, l[k]} + {{2{c[63]}}, c};
                s    = longint'(wide[63:0]);
                if (k < LIMBS - 1) begin
                    o[k] = 64'(s) & MASK;
                end else begin
                    o[k] = 64'(s);
                    ovf  = (wide[64] != wide[63]);
                end
                c = s >>> RADIX;
            end
        end
    endfunction

    task automatic push_op(input op_t l, input bit sg, input op_t e, input bit e_ovf);
        tx_t t;
        for (int k = 0; k < LIMBS; k++) begin
            t.limb   = l[k];
            t.sgn    = (k == 0) ? sg : 1'($urandom_range(1));
            t.e_limb = e[k];
            t.e_last = (k == LIMBS - 1);
            t.e_ovf  = (k == LIMBS - 1) ? e_ovf : 1'b0;
            tx_q.push_back(t);
        end
    endtask

    task automatic push_rand();
        op_t l;
        op_t e;
        bit  sg;
        bit  eo;
        for (int k = 0; k < LIMBS; k++) begin
            case ($urandom_range(4))
                0:       l[k] = MASK;
                1:       l[k] = ONES;
                2:       l[k] = 64'($urandom_range(255));
                default: l[k] = {$urandom, $urandom};
            endcase
        end
        sg = 1'($urandom_range(1));
        model(l, sg, e, eo);
        push_op(l, sg, e, eo);
    endtask

    // Drive queued limbs and score outputs; cycles in [stall_at, stall_at+stall_len) force out_ready low
    task automatic drive(input int vprob, input int rprob, input int stall_at, input int stall_len,
                         input int max_cyc, input bit must_finish);
        int          cyc;
        bit          hold;
        logic [63:0] h_limb;
        logic        h_last;
        logic        h_ovf;
        tx_t         t;
        cyc  = 0;
        hold = 1'b0;
        h_limb = '0;
        h_last = 1'b0;
        h_ovf  = 1'b0;
        while ((tx_q.size() != 0 || sb.size() != 0) && cyc < max_cyc) begin
            @(negedge clk);
            bus.in_valid  = (tx_q.size() != 0) && ($urandom_range(99) < vprob);
            bus.in_limb   = bus.in_valid ? tx_q[0].limb : {$urandom, $urandom};
            bus.in_signed = bus.in_valid ? tx_q[0].sgn : 1'($urandom_range(1));
            bus.out_ready = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0
                                                                            : ($urandom_range(99) < rprob);
            #1;
            chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            chk("in_ready", 64'(bus.in_ready), 64'((sb.size() == 0) || bus.out_ready));
            if (hold) begin
                chk("hold_limb", bus.out_limb, h_limb);
                chk("hold_last", 64'(bus.out_last), 64'(h_last));
                chk("hold_ovf", 64'(bus.out_ovf), 64'(h_ovf));
            end
            hold   = bus.out_valid && !bus.out_ready;
            h_limb = bus.out_limb;
            h_last = bus.out_last;
            h_ovf  = bus.out_ovf;
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
                t = sb.pop_front();
                chk("out_limb", bus.out_limb, t.e_limb);
                chk("out_last", 64'(bus.out_last), 64'(t.e_last));
                chk("out_ovf", 64'(bus.out_ovf), 64'(t.e_ovf));
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(tx_q.pop_front());
            end
            cyc++;
        end
        if (must_finish) begin
            chk("drain_timeout", 64'(tx_q.size() + sb.size()), 64'd0);
        end
    endtask

    op_t a;
    op_t e;

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_limb   = '0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_limb", bus.out_limb, 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned carry chain
        a = '{default: 64'd0};
        a[0] = 64'h0200_0000_0000_0005;
        a[1] = 64'h01FF_FFFF_FFFF_FFFF;
        e = '{default: 64'd0};
        e[0] = 64'h5;
        e[2] = 64'h1;
        push_op(a, 1'b0, e, 1'b0);
        drive(100, 100, -1, 0, 40, 1'b1);

        // Signed borrow propagation
        a = '{default: 64'd0};
        a[0] = ONES;
        e = '{default: MASK};
        e[LIMBS-1] = ONES;
        push_op(a, 1'b1, e, 1'b0);
        drive(100, 100, -1, 0, 40, 1'b1);

        // Unsigned top-limb overflow
        a = '{default: 64'd0};
        a[7] = 64'h0200_0000_0000_0000;
        a[8] = ONES;
        e = '{default: 64'd0};
        push_op(a, 1'b0, e, 1'b1);
        drive(100, 100, -1, 0, 40, 1'b1);

        // Backpressure on the first output for three cycles
        push_rand();
        drive(100, 100, 1, 3, 60, 1'b1);

        // Back-to-back operands: stale carry must not reach the next limb 0
        a = '{default: 64'd0};
        a[0] = 64'h0200_0000_0000_0005;
        a[1] = 64'h01FF_FFFF_FFFF_FFFF;
        e = '{default: 64'd0};
        e[0] = 64'h5;
        e[2] = 64'h1;
        push_op(a, 1'b0, e, 1'b0);
        a = '{default: 64'd0};
        a[0] = 64'h7;
        e = '{default: 64'd0};
        e[0] = 64'h7;
        push_op(a, 1'b0, e, 1'b0);
        drive(100, 100, -1, 0, 60, 1'b1);

        // Randomized operands and handshakes
        for (int n = 0; n < 8; n++) begin
            push_rand();
        end
        drive(70, 60, -1, 0, 2000, 1'b1);

        // Reset after four limbs of an operand
        a = '{default: 64'd0};
        a[0] = 64'h0200_0000_0000_0005;
        a[1] = 64'h01FF_FFFF_FFFF_FFFF;
        e = '{default: 64'd0};
        e[0] = 64'h5;
        e[2] = 64'h1;
        push_op(a, 1'b0, e, 1'b0);
        drive(100, 100, -1, 0, 4, 1'b0);
        @(posedge clk);
        #2;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        tx_q.delete();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        push_op(a, 1'b0, e, 1'b0);
        drive(100, 100, -1, 0, 40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
